// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, datapath widths and the
// response-register state encoding used by alu_share_arb.
package alu_pkg;

  localparam int ALU_DW = 32;
  localparam int ALU_CW = 4;

  typedef enum logic [ALU_CW-1:0] {
    ALU_ADD  = 4'b0000,
    ALU_ADDU = 4'b0001,
    ALU_SUB  = 4'b0010,
    ALU_AND  = 4'b0100,
    ALU_OR   = 4'b0101,
    ALU_NOR  = 4'b0110,
    ALU_XOR  = 4'b0111,
    ALU_LUI  = 4'b1001,
    ALU_SLT  = 4'b1010,
    ALU_SLTU = 4'b1011
  } alu_op_e;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } rsp_st_e;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU. Unknown control codes give zero/zf=1.
// o_overflow flags 32-bit carry-out on ADD and borrow on SUB.
module alu
  import alu_pkg::*;
(
  input  logic [ALU_DW-1:0] i_op1,
  input  logic [ALU_DW-1:0] i_op2,
  input  logic [ALU_CW-1:0] i_ctrl,
  output logic [ALU_DW-1:0] o_result,
  output logic              o_zero,
  output logic              o_overflow
);

  logic [ALU_DW:0] sum;
  logic [ALU_DW:0] diff;

  assign sum  = {1'b0, i_op1} + {1'b0, i_op2};
  assign diff = {1'b0, i_op1} - {1'b0, i_op2};

  always_comb begin
    o_result   = '0;
    o_overflow = 1'b0;
    unique case (i_ctrl)
      ALU_ADD: begin
        o_result   = sum[ALU_DW-1:0];
        o_overflow = sum[ALU_DW];
      end
      ALU_ADDU: o_result = sum[ALU_DW-1:0];
      ALU_SUB: begin
        o_result   = diff[ALU_DW-1:0];
        o_overflow = diff[ALU_DW];
      end
      ALU_AND:  o_result = i_op1 & i_op2;
      ALU_OR:   o_result = i_op1 | i_op2;
      ALU_NOR:  o_result = ~(i_op1 | i_op2);
      ALU_XOR:  o_result = i_op1 ^ i_op2;
      ALU_LUI:  o_result = {i_op2[15:0], 16'h0000};
      ALU_SLT:
        o_result = {{(ALU_DW-1){1'b0}},
                    $signed(i_op1) < $signed(i_op2)};
      ALU_SLTU:
        o_result = {{(ALU_DW-1){1'b0}}, i_op1 < i_op2};
      default:  o_result = '0;
    endcase
  end

  assign o_zero = (o_result == '0);

endmodule

// File: rtl/alu_share_arb_rr_arbiter.sv
// Round-robin pick: first valid index at or after the pointer,
// searching upward with wrap.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic [NREQ-1:0] i_valid,
  input  logic [IDW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [IDW-1:0]  o_idx,
  output logic            o_any
);

  int j;

  // Scan farthest-first so the closest valid index is the last write.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    j     = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = (int'(i_ptr) + k) % NREQ;
      if (i_valid[j]) begin
        o_gnt = NREQ'(1) << j;
        o_idx = IDW'(j);
        o_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_share_arb.sv
// One ALU shared by NREQ requesters through a round-robin grant and a
// one-entry tagged response register. Option: ALU_SHARE_OVF_EN.
module alu_share_arb
  import alu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int DW   = ALU_DW,
  parameter int CW   = ALU_CW,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NREQ-1:0]   i_req_valid,
  output logic [NREQ-1:0]   o_req_ready,
  input  logic [NREQ*DW-1:0] i_req_op1,
  input  logic [NREQ*DW-1:0] i_req_op2,
  input  logic [NREQ*CW-1:0] i_req_ctrl,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [IDW-1:0]    o_rsp_id,
  output logic [DW-1:0]     o_rsp_data,
  output logic              o_rsp_zf,
  output logic              o_rsp_ovf,
  output logic              o_busy
);

  rsp_st_e         state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  win_idx;
  logic            any_vld;
  logic            can_issue;
  logic            hs;

  logic [DW-1:0]   alu_a, alu_b, alu_res;
  logic [CW-1:0]   alu_c;
  logic            alu_zf, alu_ovf;

  logic [IDW-1:0]  rsp_id_q;
  logic [DW-1:0]   rsp_data_q;
  logic            rsp_zf_q;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .i_valid (i_req_valid),
    .i_ptr   (ptr_q),
    .o_gnt   (gnt),
    .o_idx   (win_idx),
    .o_any   (any_vld)
  );

  assign alu_a = i_req_op1[int'(win_idx)*DW +: DW];
  assign alu_b = i_req_op2[int'(win_idx)*DW +: DW];
  assign alu_c = i_req_ctrl[int'(win_idx)*CW +: CW];

  alu u_alu (
    .i_op1      (alu_a),
    .i_op2      (alu_b),
    .i_ctrl     (alu_c),
    .o_result   (alu_res),
    .o_zero     (alu_zf),
    .o_overflow (alu_ovf)
  );

  assign can_issue   = (state_q == S_EMPTY) | i_rsp_ready;
  assign hs          = any_vld & can_issue & ~i_rst;
  assign o_req_ready = gnt & {NREQ{can_issue & ~i_rst}};

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (hs) begin
      state_d = S_FULL;
      ptr_d   = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
    end else if (can_issue) begin
      state_d = S_EMPTY;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_EMPTY;
      ptr_q      <= '0;
      rsp_id_q   <= '0;
      rsp_data_q <= '0;
      rsp_zf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (hs) begin
        rsp_id_q   <= win_idx;
        rsp_data_q <= alu_res;
        rsp_zf_q   <= alu_zf;
      end
    end
  end

`ifdef ALU_SHARE_OVF_EN
  logic rsp_ovf_q;
  logic ovf_seen;

  // ovf_seen is a sticky debug flag; only reset clears it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rsp_ovf_q <= 1'b0;
      ovf_seen  <= 1'b0;
    end else if (hs) begin
      rsp_ovf_q <= alu_ovf;
      ovf_seen  <= ovf_seen | alu_ovf;
    end
  end

  assign o_rsp_ovf = rsp_ovf_q;
`else
  logic unused_ovf;

  assign unused_ovf = alu_ovf;
  assign o_rsp_ovf  = 1'b0;
`endif

  assign o_rsp_valid = (state_q == S_FULL);
  assign o_rsp_id    = rsp_id_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_rsp_zf    = rsp_zf_q;
  assign o_busy      = (state_q == S_FULL) | (|i_req_valid);

endmodule
